// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the CPU datapath.
// Datapath side drives IR and nzcv; the controller drives every strobe,
// select and the observable state and retired-instruction count.
//   master : controller view (IR/nzcv in, strobes/selects/state/instCount out)
//   slave  : datapath view (mirror image)
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      IR;
  logic [3:0]       nzcv;
  logic             writePC;
  logic [1:0]       pcSrc;
  logic             writeIR;
  logic             writeA;
  logic             writeB;
  logic             writeC;
  logic             writeF;
  logic             writeNZCV;
  logic             writeReg;
  logic [3:0]       rdAddr;
  logic             regSrc;
  logic [3:0]       aluOp;
  logic             useImm;
  logic             undef;
  logic [2:0]       state;
  logic [CNT_W-1:0] instCount;

  modport master (
    input  IR, nzcv,
    output writePC, pcSrc, writeIR, writeA, writeB, writeC, writeF,
           writeNZCV, writeReg, rdAddr, regSrc, aluOp, useImm, undef,
           state, instCount
  );

  modport slave (
    output IR, nzcv,
    input  writePC, pcSrc, writeIR, writeA, writeB, writeC, writeF,
           writeNZCV, writeReg, rdAddr, regSrc, aluOp, useImm, undef,
           state, instCount
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: fetch / decode / execute / writeback / branch,
// ARM condition evaluation against stored NZCV, halt word detection and a
// saturating retired-instruction counter.
// Ports:
//   CP    : clock, rising edge
//   reset : synchronous, active-high
//   bus   : multicycle_ctrl_if.master (IR, nzcv in; strobes, selects,
//           state and instCount out). Strobes/selects are combinational
//           from the state register and IR.
module multicycle_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] HALT_WORD = 32'hEF000000
) (
  input logic                CP,
  input logic                reset,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd7
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  // ARM condition field evaluated against N Z C V
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c && !z;
      4'b1001: cond_pass = !c || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // TST/TEQ/CMP/CMN: opcode 10xx
  logic is_cmp;
  assign is_cmp = (bus.IR[24:23] == 2'b10);

  // State register and saturating retire counter
  always_ff @(posedge CP) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next state and control strobes
  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    bus.writePC   = 1'b0;
    bus.pcSrc     = 2'b00;
    bus.writeIR   = 1'b0;
    bus.writeA    = 1'b0;
    bus.writeB    = 1'b0;
    bus.writeC    = 1'b0;
    bus.writeF    = 1'b0;
    bus.writeNZCV = 1'b0;
    bus.writeReg  = 1'b0;
    bus.rdAddr    = 4'd0;
    bus.regSrc    = 1'b0;
    bus.aluOp     = 4'd0;
    bus.useImm    = 1'b0;
    bus.undef     = 1'b0;

    case (state_q)
      FETCH: begin
        bus.writeIR = 1'b1;
        bus.writePC = 1'b1;
        bus.pcSrc   = 2'b00;
        state_d     = DECODE;
      end
      DECODE: begin
        bus.writeA = 1'b1;
        bus.writeB = 1'b1;
        bus.writeC = 1'b1;
        // Halt word is recognised even though its condition field may fail
        if (bus.IR == HALT_WORD) begin
          state_d = HALT;
        end else if (!cond_pass(bus.IR[31:28], bus.nzcv)) begin
          state_d = FETCH;
        end else if (bus.IR[27:25] == 3'b101) begin
          state_d = BRANCH;
        end else if ((bus.IR[27:26] == 2'b00) && !(is_cmp && !bus.IR[20])) begin
          state_d = EXEC;
        end else begin
          bus.undef = 1'b1;
          state_d   = FETCH;
        end
      end
      EXEC: begin
        bus.aluOp     = bus.IR[24:21];
        bus.useImm    = bus.IR[25];
        bus.writeF    = 1'b1;
        bus.writeNZCV = bus.IR[20];
        if (is_cmp) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = WB;
        end
      end
      WB: begin
        bus.rdAddr = bus.IR[15:12];
        bus.regSrc = 1'b0;
        // Rd == PC redirects the ALU result into the PC instead of the file
        if (bus.IR[15:12] != 4'hF) begin
          bus.writeReg = 1'b1;
        end else begin
          bus.writePC = 1'b1;
          bus.pcSrc   = 2'b10;
        end
        retire  = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        bus.writePC = 1'b1;
        bus.pcSrc   = 2'b01;
        if (bus.IR[24]) begin
          bus.writeReg = 1'b1;
          bus.rdAddr   = 4'd14;
          bus.regSrc   = 1'b1;
        end
        retire  = 1'b1;
        state_d = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Reset silences every strobe and select regardless of state
    if (reset) begin
      bus.writePC   = 1'b0;
      bus.pcSrc     = 2'b00;
      bus.writeIR   = 1'b0;
      bus.writeA    = 1'b0;
      bus.writeB    = 1'b0;
      bus.writeC    = 1'b0;
      bus.writeF    = 1'b0;
      bus.writeNZCV = 1'b0;
      bus.writeReg  = 1'b0;
      bus.rdAddr    = 4'd0;
      bus.regSrc    = 1'b0;
      bus.aluOp     = 4'd0;
      bus.useImm    = 1'b0;
      bus.undef     = 1'b0;
    end
  end

  assign bus.state     = state_q;
  assign bus.instCount = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: table of instructions with expected
// per-state behaviour, expanded into per-cycle expected records queued on a
// scoreboard and compared at the falling edge, plus halt/reset sequences.
// A narrow counter width lets the saturation point be reached quickly.
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W = 4;

  logic CP;
  logic reset;

  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  multicycle_ctrl #(
    .CNT_W     (CNT_W),
    .HALT_WORD (32'hEF000000)
  ) dut (
    .CP    (CP),
    .reset (reset),
    .bus   (bus)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  typedef struct packed {
    logic [2:0]       state;
    logic             wpc;
    logic [1:0]       pcsrc;
    logic             wir;
    logic             wa;
    logic             wb;
    logic             wc;
    logic             wf;
    logic             wnzcv;
    logic             wreg;
    logic [3:0]       rd;
    logic             regsrc;
    logic [3:0]       alu;
    logic             imm;
    logic             undef;
    logic [CNT_W-1:0] cnt;
  } cyc_t;

  typedef enum {K_DP, K_CMP, K_BR, K_SKIP, K_UNDEF} kind_t;

  typedef struct {
    logic [31:0] ir;
    logic [3:0]  nzcv;
    kind_t       kind;
    logic [3:0]  alu;
    logic        imm;
    logic        wn;
    logic [3:0]  rd;
    logic        link;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  cyc_t  sbq [$];
  string tagq [$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic push(input cyc_t e, input string tag);
    sbq.push_back(e);
    tagq.push_back(tag);
  endtask

  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t e;
    e       = '0;
    e.state = st;
    e.cnt   = exp_cnt;
    return e;
  endfunction

  function automatic void bump();
    if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + CNT_W'(1);
  endfunction

  // Scoreboard consumer: one expected record per cycle
  always @(negedge CP) begin
    cyc_t  e;
    cyc_t  a;
    string t;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      t = tagq.pop_front();
      a.state  = bus.state;
      a.wpc    = bus.writePC;
      a.pcsrc  = bus.pcSrc;
      a.wir    = bus.writeIR;
      a.wa     = bus.writeA;
      a.wb     = bus.writeB;
      a.wc     = bus.writeC;
      a.wf     = bus.writeF;
      a.wnzcv  = bus.writeNZCV;
      a.wreg   = bus.writeReg;
      a.rd     = bus.rdAddr;
      a.regsrc = bus.regSrc;
      a.alu    = bus.aluOp;
      a.imm    = bus.useImm;
      a.undef  = bus.undef;
      a.cnt    = bus.instCount;
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got state=%0d strobes/fields=%h required state=%0d strobes/fields=%h",
                 t, a.state, a, e.state, e);
      end
    end
  end

  // Expand one instruction record into its expected cycle sequence
  task automatic run_instr(input vec_t v, input string tag);
    cyc_t e;
    step();
    reset   = 1'b0;
    bus.IR   = v.ir;
    bus.nzcv = v.nzcv;
    e = blank(3'd0); e.wir = 1'b1; e.wpc = 1'b1;
    push(e, {tag, ".fetch"});
    step();
    e = blank(3'd1); e.wa = 1'b1; e.wb = 1'b1; e.wc = 1'b1;
    e.undef = (v.kind == K_UNDEF);
    push(e, {tag, ".decode"});
    if (v.kind == K_DP || v.kind == K_CMP) begin
      step();
      e = blank(3'd2); e.alu = v.alu; e.imm = v.imm; e.wf = 1'b1; e.wnzcv = v.wn;
      push(e, {tag, ".exec"});
    end
    if (v.kind == K_DP) begin
      step();
      e = blank(3'd3); e.rd = v.rd;
      if (v.rd == 4'hF) begin e.wpc = 1'b1; e.pcsrc = 2'b10; end
      else e.wreg = 1'b1;
      push(e, {tag, ".wb"});
    end
    if (v.kind == K_BR) begin
      step();
      e = blank(3'd4); e.wpc = 1'b1; e.pcsrc = 2'b01;
      if (v.link) begin e.wreg = 1'b1; e.rd = 4'd14; e.regsrc = 1'b1; end
      push(e, {tag, ".branch"});
    end
    if (v.kind == K_DP || v.kind == K_CMP || v.kind == K_BR) bump();
  endtask

  initial begin
    cyc_t e;
    //           ir            nzcv     kind     alu    imm   wn    rd     link
    tbl[0]  = '{32'hE0812003, 4'b0000, K_DP,    4'h4, 1'b0, 1'b0, 4'd2,  1'b0}; // ADD r2,r1,r3
    tbl[1]  = '{32'h00812003, 4'b0000, K_SKIP,  4'h0, 1'b0, 1'b0, 4'd0,  1'b0}; // ADDEQ, Z=0
    tbl[2]  = '{32'h00812003, 4'b0100, K_DP,    4'h4, 1'b0, 1'b0, 4'd2,  1'b0}; // ADDEQ, Z=1
    tbl[3]  = '{32'hE1510002, 4'b0000, K_CMP,   4'hA, 1'b0, 1'b1, 4'd0,  1'b0}; // CMP r1,r2
    tbl[4]  = '{32'hEB000004, 4'b0000, K_BR,    4'h0, 1'b0, 1'b0, 4'd0,  1'b1}; // BL
    tbl[5]  = '{32'hEA000004, 4'b0000, K_BR,    4'h0, 1'b0, 1'b0, 4'd0,  1'b0}; // B
    tbl[6]  = '{32'hE1A0F000, 4'b0000, K_DP,    4'hD, 1'b0, 1'b0, 4'd15, 1'b0}; // MOV pc,r0
    tbl[7]  = '{32'hE7000000, 4'b0000, K_UNDEF, 4'h0, 1'b0, 1'b0, 4'd0,  1'b0}; // undefined class
    tbl[8]  = '{32'hE1000000, 4'b0000, K_UNDEF, 4'h0, 1'b0, 1'b0, 4'd0,  1'b0}; // TST with S=0
    tbl[9]  = '{32'hE3A01005, 4'b0000, K_DP,    4'hD, 1'b1, 1'b0, 4'd1,  1'b0}; // MOV r1,#5
    tbl[10] = '{32'hF0812003, 4'b1111, K_SKIP,  4'h0, 1'b0, 1'b0, 4'd0,  1'b0}; // cond 1111
    tbl[11] = '{32'hC0812003, 4'b1001, K_DP,    4'h4, 1'b0, 1'b0, 4'd2,  1'b0}; // GT pass
    tbl[12] = '{32'hC0812003, 4'b0100, K_SKIP,  4'h0, 1'b0, 1'b0, 4'd0,  1'b0}; // GT fail
    tbl[13] = '{32'h80812003, 4'b0010, K_DP,    4'h4, 1'b0, 1'b0, 4'd2,  1'b0}; // HI pass
    tbl[14] = '{32'h90812003, 4'b0010, K_SKIP,  4'h0, 1'b0, 1'b0, 4'd0,  1'b0}; // LS fail
    tbl[15] = '{32'hB0812003, 4'b1000, K_DP,    4'h4, 1'b0, 1'b0, 4'd2,  1'b0}; // LT pass
    tbl[16] = '{32'hA0812003, 4'b1000, K_SKIP,  4'h0, 1'b0, 1'b0, 4'd0,  1'b0}; // GE fail
    tbl[17] = '{32'hE0912003, 4'b0000, K_DP,    4'h4, 1'b0, 1'b1, 4'd2,  1'b0}; // ADDS
    tbl[18] = '{32'hE1110002, 4'b0000, K_CMP,   4'h8, 1'b0, 1'b1, 4'd0,  1'b0}; // TST S=1
    tbl[19] = '{32'h1A000004, 4'b0000, K_BR,    4'h0, 1'b0, 1'b0, 4'd0,  1'b0}; // BNE, Z=0

    reset    = 1'b1;
    bus.IR   = 32'h0;
    bus.nzcv = 4'h0;

    // Reset state
    step();
    push(blank(3'd0), "reset");

    // Two passes: the second drives the narrow counter into saturation
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NV; i++) begin
        run_instr(tbl[i], $sformatf("p%0d.v%0d", p, i));
      end
    end

    // Halt word: decode then parked in HALT with everything quiet
    step();
    bus.IR = 32'hEF000000;
    e = blank(3'd0); e.wir = 1'b1; e.wpc = 1'b1;
    push(e, "halt.fetch");
    step();
    e = blank(3'd1); e.wa = 1'b1; e.wb = 1'b1; e.wc = 1'b1;
    push(e, "halt.decode");
    for (int k = 0; k < 20; k++) begin
      step();
      push(blank(3'd7), $sformatf("halt.hold%0d", k));
    end
    step();
    reset = 1'b1;
    push(blank(3'd7), "halt.reset");
    exp_cnt = '0;

    // One retire after reset, then reset during EXEC of an ADD
    run_instr(tbl[0], "post_reset_add");
    step();
    reset  = 1'b0;
    bus.IR = 32'hE0812003;
    e = blank(3'd0); e.wir = 1'b1; e.wpc = 1'b1;
    push(e, "rst_exec.fetch");
    step();
    e = blank(3'd1); e.wa = 1'b1; e.wb = 1'b1; e.wc = 1'b1;
    push(e, "rst_exec.decode");
    step();
    reset = 1'b1;
    push(blank(3'd2), "rst_exec.exec");
    exp_cnt = '0;
    run_instr(tbl[0], "rst_exec.after");

    step();
    step();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending records required 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the CPU datapath. It sequences each instruction through fetch, decode, execute and writeback, and generates the register-file, PC, IR, operand-latch, ALU-result and flag write strobes. It evaluates the ARM condition field against the stored NZCV flags and decodes data-processing and branch instructions. It also halts on a designated instruction word and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter
HALT_WORD, 32'hEF000000, IR value that stops execution

Ports:
CP  input  1  clock, rising edge
reset  input  1  synchronous, active-high
IR  input  32  instruction register contents
nzcv  input  4  stored flags; [3]=N [2]=Z [1]=C [0]=V
writePC  output  1  PC load strobe
pcSrc  output  2  PC source: 00=PC+4, 01=branch target, 10=ALU result F
writeIR  output  1  IR load strobe
writeA  output  1  operand latch A (Rn) strobe
writeB  output  1  operand latch B (Rm/imm) strobe
writeC  output  1  operand latch C (Rs) strobe
writeF  output  1  ALU result latch strobe
writeNZCV  output  1  flag register update strobe
writeReg  output  1  register file write strobe
rdAddr  output  4  register file write address
regSrc  output  1  write data select: 0=F, 1=PC (link)
aluOp  output  4  ALU opcode
useImm  output  1  operand 2 is immediate
undef  output  1  one-cycle pulse: undefined instruction skipped
state  output  3  FSM state
instCount  output  CNT_W  retired-instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, WB=3, BRANCH=4, HALT=7. State is registered; outputs are combinational from the state and IR.
- Reset, synchronous: state<=FETCH, instCount<=0. While reset is high, every strobe, undef, pcSrc, regSrc, aluOp, useImm and rdAddr are forced to 0. A reset asserted in any state, HALT included, wins on that edge.
- FETCH: writeIR=1, writePC=1, pcSrc=00. Next state is DECODE.
- DECODE: writeA=writeB=writeC=1.
  - Condition check on IR[31:28] uses: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 fails.
  - Priority 1: IR==HALT_WORD goes to HALT. This is checked before the condition test.
  - Priority 2: a failed condition goes to FETCH. Nothing is written and nothing is counted.
  - Priority 3: IR[27:25]==101 goes to BRANCH.
  - Priority 4: IR[27:26]==00 is data-processing. It goes to EXEC, except that opcode IR[24:21] in 1000–1011 with S=IR[20]=0 is treated as undefined.
  - Otherwise the instruction is undefined: undef=1 for this cycle, next state FETCH, no count.
- EXEC: aluOp=IR[24:21], useImm=IR[25], writeF=1, writeNZCV=IR[20].
  - Opcode 1000–1011 (TST/TEQ/CMP/CMN) goes to FETCH and increments instCount.
  - All other opcodes go to WB.
- WB: rdAddr=IR[15:12], regSrc=0.
  - If Rd≠15: writeReg=1.
  - If Rd==15: writeReg=0, writePC=1, pcSrc=10.
  - Next state is FETCH; instCount increments.
- BRANCH: writePC=1, pcSrc=01.
  - If L=IR[24]=1: also writeReg=1, rdAddr=14, regSrc=1.
  - Next state is FETCH; instCount increments.
- HALT: all strobes are 0 and the FSM stays in HALT until reset.
- Outputs not listed for a state are 0. aluOp, useImm and rdAddr hold their decoded values only in the states listed above.
- instCount saturates at all-ones and never wraps.
- Latency per instruction:
  - Data-processing with writeback: 4 cycles.
  - Compare: 3 cycles.
  - Branch: 3 cycles.
  - Skipped (condition fail or undefined): 2 cycles.
- nzcv is sampled only in DECODE. A flag update in EXEC affects only the next instruction.

Test Plan:
1. Release reset, hold IR=32'hE0812003 (ADD r2,r1,r3) -> states 0,1,2,3,0. writeIR and writePC (pcSrc=00) in cycle 1; writeA/B/C in cycle 2; writeF=1 and writeNZCV=0 in cycle 3; writeReg=1 with rdAddr=2 in cycle 4; instCount=1.
2. IR=32'h00812003 (ADDEQ), nzcv=4'b0000 -> states 0,1,0, no writeF or writeReg, instCount unchanged. Repeat with nzcv=4'b0100 -> full 4-cycle sequence, instCount increments.
3. IR=32'hE1510002 (CMP r1,r2) -> EXEC has writeF=1, writeNZCV=1, aluOp=4'b1010. Next state is FETCH with no WB; instCount +1.
4. IR=32'hEB000004 (BL) -> states 0,1,4. BRANCH has writePC=1, pcSrc=01, writeReg=1, rdAddr=14, regSrc=1. IR=32'hEA000004 (B) -> writeReg=0 in BRANCH.
5. IR=32'hE1A0F000 (MOV pc,r0) -> WB has writePC=1, pcSrc=10, writeReg=0. IR=32'hE7000000 -> undef pulse in DECODE, then FETCH, count unchanged.
6. IR=HALT_WORD -> state 7 held for 20 cycles with all strobes 0. Assert reset -> state 0, instCount=0. Assert reset during EXEC of an ADD -> no WB occurs and the next state is FETCH.
